// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one registered bitwise logic unit among NUM_REQ
// requesters; each result is returned over valid/ready tagged with its owner.
module logic_unit_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [3*NUM_REQ-1:0]     op,
   input  logic [WIDTH*NUM_REQ-1:0] a_in,
   input  logic [WIDTH*NUM_REQ-1:0] b_in,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic [ID_W-1:0]          res_id,
   output logic                     res_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 res_valid_q, res_valid_d;
   logic [WIDTH-1:0]     res_data_q, res_data_d;
   logic [ID_W-1:0]      res_id_q, res_id_d;
   logic                 res_err_q, res_err_d;

   logic [ID_W-1:0]      win_id, idx;
   logic [2:0]           sel_op;
   logic [WIDTH-1:0]     sel_a, sel_b;

   logic [2:0]           op_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [ID_W-1:0]      id_q;

   // Returns {err, data}; opcode 7 is illegal and yields zero data.
   function automatic logic [WIDTH:0] exec_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (o)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, ~a};
         3'd3:    return {1'b0, ~(a & b)};
         3'd4:    return {1'b0, ~(a | b)};
         3'd5:    return {1'b0, a ^ b};
         3'd6:    return {1'b0, ~(a ^ b)};
         default: return {1'b1, {WIDTH{1'b0}}};
      endcase
   endfunction

   // Scan downward so the candidate closest to ptr (k = 0) is written last and wins.
   always_comb begin
      win_id = '0;
      idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (req[idx]) win_id = idx;
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == win_id) begin
            sel_op = op[3*i +: 3];
            sel_a  = a_in[WIDTH*i +: WIDTH];
            sel_b  = b_in[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = '0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      res_err_d   = res_err_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = EXEC;
               gnt_d   = NUM_REQ'(1) << win_id;
               ptr_d   = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
            end
         end
         EXEC: begin
            {res_err_d, res_data_d} = exec_op(op_q, a_q, b_q);
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         res_err_q   <= res_err_d;
      end
   end

   // Winner's operands are captured once at the arbitration edge and never re-sampled.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && (|req)) begin
         op_q <= sel_op;
         a_q  <= sel_a;
         b_q  <= sel_b;
         id_q <= win_id;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Bench for logic_unit_scheduler: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin / logic-op reference model.
module tb_logic_unit_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] op;
   logic [31:0] a_in, b_in;
   logic [3:0]  gnt;
   logic        busy, res_valid, res_ready, res_err;
   logic [7:0]  res_data;
   logic [1:0]  res_id;

   int n_chk  = 0;
   int n_fail = 0;
   int mptr   = 0;

   typedef struct {
      logic [3:0] g1;
      logic       busy1;
      logic [3:0] g2;
      logic       v;
      logic [7:0] d;
      logic [1:0] id;
      logic       e;
      logic       stable;
      logic       busy_end;
      logic       v_end;
   } txn_t;

   logic_unit_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .res_err(res_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first requester at or after the pointer wins; pointer moves past it.
   function automatic int model_arbitrate(input logic [3:0] mask);
      for (int k = 0; k < 4; k++) begin
         if (mask[(mptr + k) % 4]) begin
            int w;
            w = (mptr + k) % 4;
            mptr = (w + 1) % 4;
            return w;
         end
      end
      return -1;
   endfunction

   function automatic logic [7:0] ref_op(input int o, input logic [7:0] a, input logic [7:0] b);
      case (o)
         0: return a & b;
         1: return a | b;
         2: return ~a;
         3: return ~(a & b);
         4: return ~(a | b);
         5: return a ^ b;
         6: return ~(a ^ b);
         default: return 8'h00;
      endcase
   endfunction

   // Drives one request/grant/result/handshake sequence from IDLE and records what it saw.
   task automatic run_txn(input logic [3:0] mask, input logic [11:0] ops,
                          input logic [31:0] as, input logic [31:0] bs,
                          input int hold, input logic [3:0] pend, output txn_t t);
      req = mask; op = ops; a_in = as; b_in = bs; res_ready = 1'b0;
      tick();
      t.g1 = gnt; t.busy1 = busy;
      req = 4'b0000; op = 12'($urandom); a_in = $urandom; b_in = $urandom;
      tick();
      t.g2 = gnt; t.v = res_valid; t.d = res_data; t.id = res_id; t.e = res_err;
      t.stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         req = pend; res_ready = 1'b0;
         tick();
         if (res_valid !== 1'b1 || res_data !== t.d || res_id !== t.id ||
             res_err !== t.e || gnt !== 4'b0000 || busy !== 1'b1)
            t.stable = 1'b0;
      end
      req = pend; res_ready = 1'b1;
      tick();
      t.busy_end = busy; t.v_end = res_valid;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      mptr = 0;
      n_chk++;
      if ({gnt, busy, res_valid, res_data, res_id, res_err} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got gnt=%b busy=%b valid=%b data=%h id=%0d err=%b, want all 0",
                  gnt, busy, res_valid, res_data, res_id, res_err);
      end
   endtask

   task automatic test_single();
      txn_t t;
      int   w;
      run_txn(4'b0001, 12'h000, 32'h0000_00F0, 32'h0000_003C, 0, 4'b0000, t);
      w = model_arbitrate(4'b0001);
      n_chk++;
      if (t.g1 !== 4'b0001 || t.busy1 !== 1'b1 || w != 0) begin
         n_fail++;
         $display("FAIL single_grant: got gnt=%b busy=%b, want gnt=0001 busy=1", t.g1, t.busy1);
      end
      n_chk++;
      if (t.g2 !== 4'b0000 || t.v !== 1'b1 || t.d !== 8'h30 || t.id !== 2'd0 || t.e !== 1'b0) begin
         n_fail++;
         $display("FAIL single_result: got gnt=%b valid=%b data=%h id=%0d err=%b, want 0000 1 30 0 0",
                  t.g2, t.v, t.d, t.id, t.e);
      end
      n_chk++;
      if (t.busy_end !== 1'b0 || t.v_end !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got busy=%b valid=%b, want 0 0", t.busy_end, t.v_end);
      end
   endtask

   task automatic test_opcode_sweep();
      logic [7:0] exp_d [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
      txn_t t;
      int   w;
      for (int o = 0; o < 8; o++) begin
         run_txn(4'b0100, 12'(o) << 6, 32'h00A5_0000, 32'h000F_0000, 0, 4'b0000, t);
         w = model_arbitrate(4'b0100);
         n_chk++;
         if (t.d !== exp_d[o] || t.e !== (o == 7) || t.id !== 2'(w) || t.g1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL opcode_%0d: got data=%h err=%b id=%0d gnt=%b, want data=%h err=%0d id=2 gnt=0100",
                     o, t.d, t.e, t.id, t.g1, exp_d[o], (o == 7));
         end
      end
   endtask

   task automatic test_round_robin();
      int   order [5] = '{0, 1, 2, 3, 0};
      txn_t t;
      int   w;
      rst = 1'b1; tick(); rst = 1'b0; mptr = 0;
      for (int n = 0; n < 5; n++) begin
         run_txn(4'b1111, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
         w = model_arbitrate(4'b1111);
         n_chk++;
         if (t.g1 !== (4'b0001 << order[n]) || t.id !== 2'(order[n]) || w != order[n] ||
             t.busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got gnt=%b id=%0d busy_end=%b, want requester %0d",
                     n, t.g1, t.id, t.busy_end, order[n]);
         end
      end
   endtask

   task automatic test_backpressure();
      txn_t t;
      int   w;
      run_txn(4'b0001, 12'h001, 32'h0000_0012, 32'h0000_0034, 5, 4'b1010, t);
      w = model_arbitrate(4'b0001);
      n_chk++;
      if (t.stable !== 1'b1 || t.v !== 1'b1 || t.d !== ref_op(1, 8'h12, 8'h34) || t.id !== 2'(w)) begin
         n_fail++;
         $display("FAIL backpressure_hold: got stable=%b valid=%b data=%h id=%0d, want 1 1 %h %0d",
                  t.stable, t.v, t.d, t.id, ref_op(1, 8'h12, 8'h34), w);
      end
      n_chk++;
      if (t.busy_end !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release: got busy=%b, want 0", t.busy_end);
      end
      run_txn(4'b1010, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
      w = model_arbitrate(4'b1010);
      n_chk++;
      if (t.g1 !== 4'b0010 || w != 1) begin
         n_fail++;
         $display("FAIL backpressure_next: got gnt=%b, want 0010", t.g1);
      end
   endtask

   task automatic test_pointer_wrap();
      txn_t t;
      int   w;
      run_txn(4'b1000, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
      w = model_arbitrate(4'b1000);
      n_chk++;
      if (t.g1 !== 4'b1000 || t.id !== 2'd3) begin
         n_fail++;
         $display("FAIL wrap_first: got gnt=%b id=%0d, want 1000 3", t.g1, t.id);
      end
      run_txn(4'b1001, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
      w = model_arbitrate(4'b1001);
      n_chk++;
      if (t.g1 !== 4'b0001 || t.id !== 2'd0 || w != 0) begin
         n_fail++;
         $display("FAIL wrap_second: got gnt=%b id=%0d, want 0001 0", t.g1, t.id);
      end
   endtask

   task automatic test_reset_mid_op();
      txn_t t;
      int   w;
      req = 4'b0100; op = 12'($urandom); a_in = $urandom; b_in = $urandom;
      tick();
      req = 4'b0000; rst = 1'b1;
      tick();
      rst = 1'b0; mptr = 0;
      n_chk++;
      if ({gnt, busy, res_valid, res_data, res_id, res_err} !== 16'h0) begin
         n_fail++;
         $display("FAIL midop_reset: got gnt=%b busy=%b valid=%b data=%h id=%0d err=%b, want all 0",
                  gnt, busy, res_valid, res_data, res_id, res_err);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_chk++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_discard: got valid=%b busy=%b, want 0 0", res_valid, busy);
      end
      run_txn(4'b1010, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
      w = model_arbitrate(4'b1010);
      n_chk++;
      if (t.g1 !== 4'b0010 || w != 1) begin
         n_fail++;
         $display("FAIL midop_first: got gnt=%b, want 0010", t.g1);
      end
      run_txn(4'b1010, 12'($urandom), $urandom, $urandom, 0, 4'b0000, t);
      w = model_arbitrate(4'b1010);
      n_chk++;
      if (t.g1 !== 4'b1000 || w != 3) begin
         n_fail++;
         $display("FAIL midop_second: got gnt=%b, want 1000", t.g1);
      end
   endtask

   task automatic test_random();
      txn_t        t;
      int          w, o;
      logic [3:0]  mask;
      logic [11:0] ops;
      logic [31:0] as, bs;
      logic [7:0]  ed;
      for (int n = 0; n < 40; n++) begin
         mask = 4'($urandom_range(1, 15));
         ops  = 12'($urandom);
         as   = $urandom;
         bs   = $urandom;
         run_txn(mask, ops, as, bs, $urandom_range(0, 3), 4'b0000, t);
         w  = model_arbitrate(mask);
         o  = int'(ops[3*w +: 3]);
         ed = ref_op(o, as[8*w +: 8], bs[8*w +: 8]);
         n_chk++;
         if (t.g1 !== (4'b0001 << w) || t.v !== 1'b1 || t.d !== ed || t.id !== 2'(w) ||
             t.e !== (o == 7) || t.stable !== 1'b1 || t.busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d: mask=%b got gnt=%b data=%h id=%0d err=%b stable=%b, want gnt=%b data=%h id=%0d err=%0d",
                     n, mask, t.g1, t.d, t.id, t.e, t.stable, 4'b0001 << w, ed, w, (o == 7));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_opcode_sweep();
      test_round_robin();
      test_backpressure();
      test_pointer_wrap();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_unit_scheduler.md
Name: logic_unit_scheduler

Overview:
- Shares one bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's opcode and operands, computes a registered result, and returns it over a valid/ready handshake tagged with the requester index.
- Sits between the gate datapath and its client blocks. It is the single sequencing point for gate operations.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), requester index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request, level.
- op  input  3*NUM_REQ  opcode per requester; requester i uses bits [3i+2:3i].
- a_in  input  WIDTH*NUM_REQ  operand A per requester, packed the same way.
- b_in  input  WIDTH*NUM_REQ  operand B per requester.
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle long.
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  result.
- res_id  output  ID_W  index of the requester that owns res_data.
- res_err  output  1  illegal opcode flag, qualified by res_valid.

Behaviour:
- Reset: gnt=0, busy=0, res_valid=0, res_data=0, res_id=0, res_err=0, state=IDLE, rr pointer ptr=0. Reset takes priority over every other event.
- Reset mid-operation: any in-flight operation or held result is discarded with no handshake.
- FSM states: IDLE, EXEC, RESULT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set at an edge:
  - Winner = first set bit searching ptr, ptr+1, … with modulo NUM_REQ wrap.
  - Latch op/a/b/index of the winner.
  - Drive gnt[winner]=1 in the next cycle (EXEC) only.
  - ptr <= (winner+1) mod NUM_REQ.
  - Go to EXEC.
- EXEC: compute from latched operands. At the edge, register res_data/res_id/res_err, set res_valid=1, go to RESULT. gnt returns to 0.
- RESULT:
  - res_data, res_id and res_err stay stable while res_valid=1 and res_ready=0.
  - On an edge with res_ready=1: res_valid <= 0, go to IDLE.
  - res_ready is ignored outside RESULT.
- Latency: req sampled at edge T → gnt high in cycle T+1 → res_valid high in cycle T+2. With res_ready held high the next arbitration edge is T+3. Peak throughput is one operation per 3 cycles.
- Requester rule: req must be deasserted in the cycle after gnt. A req still high when the FSM re-enters IDLE counts as a new request.
- Inputs from non-winning requesters are ignored. Operands are not re-sampled after the IDLE edge.
- Opcode encoding (bitwise over WIDTH):
  - 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is illegal: res_data=0, res_err=1. The result is still returned and the handshake completes normally.
- No arithmetic and no width growth: the result is exactly WIDTH bits.
- Simultaneous requests: exactly one grant per arbitration. Losers wait, and each requester is served within NUM_REQ arbitrations.
- busy=1 in EXEC and RESULT, 0 in IDLE.

Test Plan (NUM_REQ=4, WIDTH=8):
1. Single request: req=0001, op0=0, a0=0xF0, b0=0x3C sampled at edge T → gnt=0001 in cycle T+1 only; cycle T+2 shows res_valid=1, res_data=0x30, res_id=0, res_err=0; with res_ready=1, busy drops in T+3.
2. Opcode sweep on requester 2, a=0xA5, b=0x0F, op 0..7 → results 0x05, 0xAF, 0x5A, 0xFA, 0x50, 0xAA, 0x55, 0x00. res_err=1 only for op 7.
3. Round-robin fairness: req=1111 held, res_ready=1, each requester drops req after its grant and re-raises it → grant order 0,1,2,3,0 at 3-cycle spacing; res_id matches each grant.
4. Backpressure: result pending with res_ready=0 for 5 cycles → res_valid, res_data and res_id stable; no gnt while req=1010 is pending. res_ready=1 → IDLE, then gnt=0010 on the next arbitration.
5. Pointer wrap: after a grant to requester 3, assert req=1001 → gnt=0001 (requester 0 wins, ptr wrapped).
6. Reset mid-op: assert rst during EXEC → next cycle all outputs 0, state IDLE, ptr=0; with req=1010 after reset → gnt=0010 first, then 1000.
